// File: rtl/chain_toggle_sequencer_pkg.sv
// Shared types for the chain toggle sequencer: FSM states, fail codes and the
// helper that gives the chain output level expected for a given drive level.
package chain_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        WAIT   = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4,
        FAIL   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'b00,
        FC_TIMEOUT = 2'b01,
        FC_GLITCH  = 2'b10,
        FC_XZ      = 2'b11
    } fail_code_t;

    // An odd number of inverters flips the level; an even number passes it.
    function automatic logic expected_polarity(input logic drv, input int unsigned num_stages);
        return drv ^ ((num_stages % 2) != 0);
    endfunction

endpackage

// File: rtl/chain_toggle_sequencer_settle_timer.sv
// Settle timer for the chain toggle sequencer: elapsed-clock counter plus a
// consecutive-match counter, both saturating, cleared once per toggle.
module chain_settle_timer #(
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = 16,
    parameter int STABLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             match,
    output logic             timeout,
    output logic             stable_done,
    output logic [CNT_W-1:0] latency
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAT_ADJ   = CNT_W'(STABLE_CYC - 1);
    localparam logic [3:0]       STABLE_C  = 4'(STABLE_CYC);

    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] elapsed;
    logic [3:0]       stable;
    logic [3:0]       stable_inc;
    logic [3:0]       stable_nxt;

    // elapsed counts the current cycle, so the first WAIT cycle is clock 1
    always_comb begin
        elapsed     = (timer == '1) ? timer : timer + CNT_W'(1);
        stable_inc  = (stable == 4'hf) ? stable : stable + 4'd1;
        stable_nxt  = match ? stable_inc : 4'd0;
        timeout     = (elapsed >= TIMEOUT_C);
        stable_done = match && (stable_inc >= STABLE_C);
        latency     = elapsed - LAT_ADJ;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            timer  <= '0;
            stable <= '0;
        end else if (enable) begin
            timer  <= elapsed;
            stable <= stable_nxt;
        end
    end

endmodule

// File: rtl/chain_toggle_sequencer.sv
// Toggles an inverter chain, waits for a stable response, records latency.
// Optional X/Z detection on chain_out: define CHAIN_TOGGLE_SEQUENCER_XDETECT_EN.
module chain_toggle_sequencer
    import chain_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 5,
    parameter int TIMEOUT     = 16,
    parameter int STABLE_CYC  = 2,
    parameter int NUM_TOGGLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             chain_out,
    output logic             drv,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] lat_last
);

    localparam logic [CNT_W-1:0] NUM_TOG_C = CNT_W'(NUM_TOGGLES);

    state_t           state_q;
    state_t           state_d;
    logic             drv_q;
    logic             drv_d;
    logic [CNT_W-1:0] pass_q;
    logic [CNT_W-1:0] pass_d;
    logic [CNT_W-1:0] pass_inc;
    logic [CNT_W-1:0] lat_q;
    logic [CNT_W-1:0] lat_d;
    fail_code_t       fc_q;
    fail_code_t       fc_d;

    logic             expected;
    logic             match;
    logic             xz;
    logic             tmr_clear;
    logic             tmr_en;
    logic             timeout;
    logic             stable_done;
    logic [CNT_W-1:0] latency;

    assign expected = expected_polarity(drv_q, NUM_STAGES);
    assign pass_inc = (pass_q == '1) ? pass_q : pass_q + CNT_W'(1);

`ifdef CHAIN_TOGGLE_SEQUENCER_XDETECT_EN
    assign xz = (chain_out !== 1'b0) && (chain_out !== 1'b1);
`else
    assign xz = 1'b0;
`endif

    // Written as an if so an unknown chain_out resolves to a mismatch.
    always_comb begin
        match = 1'b0;
        if (chain_out == expected) begin
            match = 1'b1;
        end
    end

    chain_settle_timer #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .STABLE_CYC (STABLE_CYC)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .clear       (tmr_clear),
        .enable      (tmr_en),
        .match       (match),
        .timeout     (timeout),
        .stable_done (stable_done),
        .latency     (latency)
    );

    always_comb begin
        state_d   = state_q;
        drv_d     = drv_q;
        pass_d    = pass_q;
        lat_d     = lat_q;
        fc_d      = fc_q;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    pass_d  = '0;
                end
            end
            DRIVE: begin
                drv_d     = ~drv_q;
                tmr_clear = 1'b1;
                state_d   = WAIT;
            end
            WAIT, SETTLE: begin
                tmr_en = 1'b1;
                // Order sets priority: X/Z, then a completed settle beats timeout.
                if (xz) begin
                    state_d = FAIL;
                    fc_d    = FC_XZ;
                end else if (stable_done) begin
                    lat_d   = latency;
                    pass_d  = pass_inc;
                    state_d = (pass_inc == NUM_TOG_C) ? DONE : DRIVE;
                end else if ((state_q == SETTLE) && !match) begin
                    state_d = FAIL;
                    fc_d    = FC_GLITCH;
                end else if (timeout) begin
                    state_d = FAIL;
                    fc_d    = FC_TIMEOUT;
                end else if (match) begin
                    state_d = SETTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            drv_q   <= 1'b0;
            pass_q  <= '0;
            lat_q   <= '0;
            fc_q    <= FC_NONE;
        end else begin
            state_q <= state_d;
            drv_q   <= drv_d;
            pass_q  <= pass_d;
            lat_q   <= lat_d;
            fc_q    <= fc_d;
        end
    end

    assign drv       = drv_q;
    assign busy      = (state_q == DRIVE) || (state_q == WAIT) || (state_q == SETTLE);
    assign done      = (state_q == DONE);
    assign fail      = (state_q == FAIL);
    assign fail_code = fc_q;
    assign pass_cnt  = pass_q;
    assign lat_last  = lat_q;

endmodule

// File: tb/tb_chain_toggle_sequencer.sv
// Bench for chain_toggle_sequencer: per-toggle chain responses, outcomes
// predicted from the settle/timeout/glitch rules.
module tb_chain_toggle_sequencer;

    localparam int NUM_STAGES  = 5;
    localparam int TIMEOUT     = 16;
    localparam int STABLE_CYC  = 2;
    localparam int NUM_TOGGLES = 8;
    localparam int CNT_W       = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             chain_out;
    logic             drv;
    logic             busy;
    logic             done;
    logic             fail;
    logic [1:0]       fail_code;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] lat_last;

    always #5 clk = ~clk;

    chain_toggle_sequencer #(
        .NUM_STAGES  (NUM_STAGES),
        .TIMEOUT     (TIMEOUT),
        .STABLE_CYC  (STABLE_CYC),
        .NUM_TOGGLES (NUM_TOGGLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .chain_out (chain_out),
        .drv       (drv),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_code (fail_code),
        .pass_cnt  (pass_cnt),
        .lat_last  (lat_last)
    );

    // Per toggle: first WAIT cycle (1-based) whose output is correct, and an
    // optional later cycle where the output glitches back (0 = none).
    int   d_arr [NUM_TOGGLES];
    int   g_arr [NUM_TOGGLES];
    int   tog_idx = -1;
    int   k = 0;
    logic last_drv = 1'b0;

    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   m_lat   = 0;

    // Chain environment: restarts its cycle count whenever drv changes.
    always @(posedge clk) begin
        int   dd;
        int   gg;
        logic expv;
        #1;
        if (drv !== last_drv) begin
            tog_idx = tog_idx + 1;
            k = 1;
        end else begin
            k = k + 1;
        end
        last_drv = drv;
        dd = 1;
        gg = 0;
        if (tog_idx >= 0 && tog_idx < NUM_TOGGLES) begin
            dd = d_arr[tog_idx];
            gg = g_arr[tog_idx];
        end
        expv = drv ^ ((NUM_STAGES % 2) != 0);
        chain_out = (k >= dd && k != gg) ? expv : ~expv;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Outcome of one run: cycles from the start edge to the done/fail
    // observation, pass/fail, fail code, passed toggles. Updates m_lat.
    task automatic predict(output int ev, output bit ok, output int code, output int pc);
        int sum;
        int dd;
        int gg;
        int fin;
        sum  = 0;
        ok   = 1'b1;
        code = 0;
        pc   = 0;
        ev   = 0;
        for (int i = 0; i < NUM_TOGGLES; i++) begin
            dd  = d_arr[i];
            gg  = g_arr[i];
            fin = dd + STABLE_CYC - 1;
            if (dd > TIMEOUT) begin
                ok = 1'b0; code = 1; ev = sum + TIMEOUT + 2;
                return;
            end
            if (gg > dd && gg <= fin && gg <= TIMEOUT) begin
                ok = 1'b0; code = 2; ev = sum + gg + 2;
                return;
            end
            if (fin > TIMEOUT) begin
                ok = 1'b0; code = 1; ev = sum + TIMEOUT + 2;
                return;
            end
            pc++;
            m_lat = dd;
            sum += dd + STABLE_CYC;
        end
        ev = sum + 1;
    endtask

    task automatic set_all(input int dd, input int gg);
        for (int i = 0; i < NUM_TOGGLES; i++) begin
            d_arr[i] = dd;
            g_arr[i] = gg;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_drv"}, drv, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_code"}, fail_code, 0);
        check({tag, "_pass_cnt"}, pass_cnt, 0);
        check({tag, "_lat_last"}, lat_last, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
        m_lat = 0;
    endtask

    task automatic do_run(input string tag);
        int ev;
        int code;
        int pc;
        int cyc;
        bit ok;
        bit seen;
        logic drv_hold;
        predict(ev, ok, code, pc);
        tog_idx = -1;
        last_drv = drv;
        start = 1'b1;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 1000) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cyc == 1) check({tag, "_busy_drive"}, busy, 1);
            if (done || fail) seen = 1'b1;
        end
        check({tag, "_event_seen"}, seen, 1);
        check({tag, "_event_cycle"}, cyc, ev);
        check({tag, "_done"}, done, ok);
        check({tag, "_fail"}, fail, !ok);
        check({tag, "_code"}, fail_code, code);
        check({tag, "_pass_cnt"}, pass_cnt, pc);
        check({tag, "_lat_last"}, lat_last, m_lat);
        check({tag, "_busy_end"}, busy, 0);
        @(negedge clk);
        if (ok) begin
            check({tag, "_done_once"}, done, 0);
            check({tag, "_idle_busy"}, busy, 0);
            check({tag, "_hold_cnt"}, pass_cnt, pc);
        end else begin
            drv_hold = drv;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            check({tag, "_fail_sticky"}, fail, 1);
            check({tag, "_fail_busy"}, busy, 0);
            check({tag, "_fail_code_hold"}, fail_code, code);
            check({tag, "_fail_drv_hold"}, drv, drv_hold);
            do_reset();
        end
    endtask

    initial begin
        int  sel;
        bit  found;
        rst = 1'b1;
        start = 1'b0;
        set_all(1, 0);
        repeat (2) @(negedge clk);
        check_reset_vals("init");
        rst = 1'b0;
        @(negedge clk);

        set_all(3, 0);
        do_run("ideal_d3");
        set_all(15, 0);
        do_run("boundary_d15");
        set_all(1, 0);
        do_run("fast_d1");

        set_all(1, 0);
        d_arr[1] = 255;
        do_run("stuck_second");

        set_all(3, 0);
        d_arr[0] = 16;
        do_run("late_d16");

        set_all(3, 0);
        d_arr[0] = 2;
        g_arr[0] = 3;
        do_run("glitch");

        // Reset while settling on the fourth toggle.
        set_all(3, 0);
        tog_idx = -1;
        last_drv = drv;
        start = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (tog_idx == 3 && k == 4) found = 1'b1;
        end
        check("mid_reached", found, 1);
        check("mid_busy", busy, 1);
        do_reset();
        @(negedge clk);
        do_run("after_mid_reset");

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < NUM_TOGGLES; i++) begin
                sel = $urandom_range(0, 99);
                if (sel < 80) d_arr[i] = $urandom_range(1, 6);
                else if (sel < 94) d_arr[i] = $urandom_range(12, 17);
                else d_arr[i] = 255;
                sel = $urandom_range(0, 99);
                g_arr[i] = (d_arr[i] < 200 && sel < 8) ? d_arr[i] + 1 : 0;
            end
            do_run("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
